reg_desplazamiento_param: RTL and testbench

- Parametrised universal shift register; next generation of the fixed 32-bit structural/behavioural register.
- Generalises width and segment size. Adds arithmetic shift, per-segment serial outputs and a multi-cycle "shift by CNT" operation with a BUSY/DONE handshake.
- Sits in the registro_* family and is driven by the same Test*/verificador style benches.

---
 rtl/reg_desplazamiento_param.sv | 163 ++++++++++++++++
 tb/tb_reg_desplazamiento_param.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_desplazamiento_param.sv
// Parametrised universal shift register.
// Single-cycle operations: hold, logical shift, rotate, parallel load and
// arithmetic shift, each by one bit. There is also a multi-cycle "shift by
// CNT" operation that runs under a small IDLE/SHIFT/FIN control FSM and
// reports progress through BUSY (while shifting) and DONE (one-cycle
// completion pulse).
// S_OUT holds, for each SEG-bit segment, the bit that left that segment on
// the most recent single-bit shift or rotate.
// WIDTH must be an integer multiple of SEG, and WIDTH must be at least 2.

module reg_desplazamiento_param #(
  parameter int WIDTH = 32,
  parameter int SEG   = 4,
  parameter int CNT_W = 5
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   ENB,
  input  logic                   DIR,
  input  logic                   S_IN,
  input  logic [2:0]             MODO,
  input  logic [CNT_W-1:0]       CNT,
  input  logic                   START,
  input  logic [WIDTH-1:0]       D,
  output logic [WIDTH-1:0]       Q,
  output logic [WIDTH/SEG-1:0]   S_OUT,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int NSEG = WIDTH / SEG;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  localparam logic [2:0] MODO_HOLD  = 3'b000;
  localparam logic [2:0] MODO_SHIFT = 3'b001;
  localparam logic [2:0] MODO_ROT   = 3'b010;
  localparam logic [2:0] MODO_LOAD  = 3'b011;
  localparam logic [2:0] MODO_ARITH = 3'b100;
  localparam logic [2:0] MODO_MULTI = 3'b101;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [NSEG-1:0]  s_out_q, s_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;   // direction latched at START
  logic             sin_q, sin_d;   // serial fill bit latched at START

  // One-bit move; 'fill' enters the end that the shift vacates.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input logic             right,
                                                 input logic             fill);
    return right ? {fill, v[WIDTH-1:1]} : {v[WIDTH-2:0], fill};
  endfunction

  // Bit that leaves each segment: the segment MSB when moving left,
  // the segment LSB when moving right.
  function automatic logic [NSEG-1:0] exit_bits(input logic [WIDTH-1:0] v,
                                                input logic             right);
    logic [NSEG-1:0] r;
    for (int k = 0; k < NSEG; k++) begin
      r[k] = right ? v[k*SEG] : v[(k+1)*SEG-1];
    end
    return r;
  endfunction

  // Next-state logic for the datapath and the multi-cycle control FSM.
  always_comb begin
    // NOTE: every signal gets its hold value before any branch so that no
    // path leaves it unassigned; otherwise synthesis would infer latches.
    state_d = state_q;
    q_d     = q_q;
    s_out_d = s_out_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    sin_d   = sin_q;

    case (state_q)
      ST_IDLE: begin
        if (ENB) begin
          case (MODO)
            MODO_SHIFT: begin
              q_d     = shift_one(q_q, DIR, S_IN);
              s_out_d = exit_bits(q_q, DIR);
            end
            MODO_ROT: begin
              q_d     = shift_one(q_q, DIR, DIR ? q_q[0] : q_q[WIDTH-1]);
              s_out_d = exit_bits(q_q, DIR);
            end
            MODO_LOAD: begin
              q_d     = D;
              s_out_d = '0;
            end
            MODO_ARITH: begin
              // Right keeps the sign bit; left always brings in a zero.
              q_d     = shift_one(q_q, DIR, DIR ? q_q[WIDTH-1] : 1'b0);
              s_out_d = exit_bits(q_q, DIR);
            end
            MODO_MULTI: begin
              if (START) begin
                cnt_d   = CNT;
                dir_d   = DIR;
                sin_d   = S_IN;
                state_d = (CNT == '0) ? ST_FIN : ST_SHIFT;
              end
            end
            default: ;  // MODO_HOLD and the unused codes leave everything as is
          endcase
        end
      end

      ST_SHIFT: begin
        // The live mode/data/direction inputs are ignored here; only ENB
        // matters, and ENB=0 simply pauses the run.
        if (ENB) begin
          q_d     = shift_one(q_q, dir_q, sin_q);
          s_out_d = exit_bits(q_q, dir_q);
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_FIN;
          end
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      s_out_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      sin_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before the edge, independent of statement order.
      state_q <= state_d;
      q_q     <= q_d;
      s_out_q <= s_out_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      sin_q   <= sin_d;
    end
  end

  assign Q     = q_q;
  assign S_OUT = s_out_q;
  assign BUSY  = (state_q == ST_SHIFT);
  assign DONE  = (state_q == ST_FIN);

endmodule

// File: tb/tb_reg_desplazamiento_param.sv
// Self-checking bench for reg_desplazamiento_param (WIDTH=32, SEG=4, CNT_W=5).
// The driver applies inputs on the falling edge. It steps a behavioural model
// and pushes the expected Q/S_OUT/BUSY/DONE into a scoreboard queue. A
// separate monitor pops one entry after each rising edge and compares it
// against the DUT.

module tb_reg_desplazamiento_param;

  localparam int W  = 32;
  localparam int SG = 4;
  localparam int NS = W / SG;

  logic          CLK;
  logic          RESET_N;
  logic          ENB;
  logic          DIR;
  logic          S_IN;
  logic [2:0]    MODO;
  logic [4:0]    CNT;
  logic          START;
  logic [W-1:0]  D;
  logic [W-1:0]  Q;
  logic [NS-1:0] S_OUT;
  logic          BUSY;
  logic          DONE;

  reg_desplazamiento_param #(.WIDTH(W), .SEG(SG), .CNT_W(5)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENB(ENB), .DIR(DIR), .S_IN(S_IN),
    .MODO(MODO), .CNT(CNT), .START(START), .D(D),
    .Q(Q), .S_OUT(S_OUT), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [W-1:0]  q;
    logic [NS-1:0] so;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_cmp  = 0;
  int n_fail = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  // Reference model: register value, exit bits, shifts still owed, and a flag
  // for the one-cycle completion phase.
  logic [W-1:0]  m_q;
  logic [NS-1:0] m_so;
  int            m_left;
  bit            m_fin;
  bit            m_dir;
  bit            m_sin;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_shift(input logic [W-1:0] v, input bit right, input bit fill);
    logic [W-1:0] f;
    f = W'(fill);
    return right ? ((v >> 1) | (f << (W - 1))) : ((v << 1) | f);
  endfunction

  function automatic logic [NS-1:0] m_exit(input logic [W-1:0] v, input bit right);
    logic [NS-1:0] r;
    for (int k = 0; k < NS; k++) r[k] = right ? v[SG*k] : v[SG*k + SG - 1];
    return r;
  endfunction

  // One clock of the model, given the inputs sampled at that edge.
  task automatic model_step(input bit enb, input bit dir, input bit sin, input logic [2:0] modo,
                            input int cnt, input bit start, input logic [W-1:0] d);
    if (m_fin) begin
      m_fin = 0;
    end else if (m_left > 0) begin
      if (enb) begin
        m_so = m_exit(m_q, m_dir);
        m_q  = m_shift(m_q, m_dir, m_sin);
        m_left--;
        if (m_left == 0) m_fin = 1;
      end
    end else if (enb) begin
      case (modo)
        3'b001: begin m_so = m_exit(m_q, dir); m_q = m_shift(m_q, dir, sin); end
        3'b010: begin m_so = m_exit(m_q, dir); m_q = m_shift(m_q, dir, dir ? m_q[0] : m_q[W-1]); end
        3'b011: begin m_q = d; m_so = '0; end
        3'b100: begin
          m_so = m_exit(m_q, dir);
          m_q  = dir ? W'($signed(m_q) >>> 1) : (m_q << 1);
        end
        3'b101: if (start) begin
          m_dir = dir;
          m_sin = sin;
          if (cnt == 0) m_fin = 1;
          else m_left = cnt;
        end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle from a falling edge; returns at the next falling edge.
  task automatic cycle(input bit enb, input bit dir, input bit sin, input logic [2:0] modo,
                       input int cnt, input bit start, input logic [W-1:0] d);
    exp_t e;
    ENB = enb; DIR = dir; S_IN = sin; MODO = modo; CNT = 5'(cnt); START = start; D = d;
    model_step(enb, dir, sin, modo, cnt, start, d);
    e.q = m_q; e.so = m_so; e.busy = (m_left > 0); e.done = m_fin;
    sb.push_back(e);
    @(negedge CLK);
  endtask

  task automatic junk_cycle(input bit enb);
    cycle(enb, 1'($urandom), 1'($urandom), 3'($urandom), $urandom_range(0, 31), 1'($urandom), $urandom);
  endtask

  // Keep the FSM fed with irrelevant inputs until the model is idle again.
  task automatic run_to_idle();
    for (int i = 0; i < 80 && (m_left > 0 || m_fin); i++) junk_cycle(1'b1);
  endtask

  task automatic load(input logic [W-1:0] v);
    cycle(1'b1, 1'b0, 1'b0, 3'b011, 0, 1'b0, v);
  endtask

  // Assert reset in mid-cycle and check that it acts without a clock edge.
  task automatic do_reset();
    RESET_N = 1'b0;
    ENB = 1'b0; START = 1'b0; MODO = 3'b000;
    sb.delete();
    m_q = '0; m_so = '0; m_left = 0; m_fin = 0; m_dir = 0; m_sin = 0;
    #1;
    check("reset_q", 64'(Q), 64'h0);
    check("reset_s_out", 64'(S_OUT), 64'h0);
    check("reset_busy", 64'(BUSY), 64'h0);
    check("reset_done", 64'(DONE), 64'h0);
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  // Monitor: after every rising edge compare the DUT against the oldest
  // expectation, and count BUSY/DONE cycles for the handshake checks.
  always @(posedge CLK) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("cycle", {22'h0, Q, S_OUT, BUSY, DONE},
            {22'h0, mon_e.q, mon_e.so, mon_e.busy, mon_e.done});
    end
    if (BUSY) busy_cnt++;
    if (DONE) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; ENB = 0; DIR = 0; S_IN = 0; MODO = 0; CNT = 0; START = 0; D = '0;
    @(negedge CLK);
    do_reset();

    // Load, then a logical left shift and a disabled cycle.
    load(32'hA5A51234);
    check("load_q", 64'(Q), 64'hA5A51234);
    check("load_s_out", 64'(S_OUT), 64'h00);
    load(32'h80000001);
    cycle(1'b1, 1'b0, 1'b1, 3'b001, 0, 1'b0, '0);
    check("shl_q", 64'(Q), 64'h00000003);
    check("shl_s_out", 64'(S_OUT), 64'h80);
    cycle(1'b0, 1'b0, 1'b1, 3'b001, 0, 1'b0, '0);
    check("enb0_q", 64'(Q), 64'h00000003);

    // Rotate right and arithmetic right.
    load(32'h00000001);
    cycle(1'b1, 1'b1, 1'b0, 3'b010, 0, 1'b0, '0);
    check("rotr_q", 64'(Q), 64'h80000000);
    check("rotr_s_out", 64'(S_OUT), 64'h01);
    load(32'hF0000000);
    cycle(1'b1, 1'b1, 1'b0, 3'b100, 0, 1'b0, '0);
    check("asr_q", 64'(Q), 64'hF8000000);

    // Multi-cycle shift by 4, inputs scrambled while it runs.
    load(32'h0000000F);
    busy_cnt = 0; done_cnt = 0;
    cycle(1'b1, 1'b0, 1'b0, 3'b101, 4, 1'b1, '0);
    run_to_idle();
    check("multi4_q", 64'(Q), 64'h000000F0);
    check("multi4_busy_cycles", 64'(busy_cnt), 64'd4);
    check("multi4_done_cycles", 64'(done_cnt), 64'd1);

    // Same, with a two-cycle pause in the middle.
    load(32'h0000000F);
    busy_cnt = 0; done_cnt = 0;
    cycle(1'b1, 1'b0, 1'b0, 3'b101, 4, 1'b1, '0);
    junk_cycle(1'b1);
    junk_cycle(1'b0);
    junk_cycle(1'b0);
    run_to_idle();
    check("pause_q", 64'(Q), 64'h000000F0);
    check("pause_busy_cycles", 64'(busy_cnt), 64'd6);
    check("pause_done_cycles", 64'(done_cnt), 64'd1);

    // CNT=0 goes straight to DONE.
    load(32'h12345678);
    busy_cnt = 0; done_cnt = 0;
    cycle(1'b1, 1'b0, 1'b1, 3'b101, 0, 1'b1, '0);
    check("cnt0_done", 64'(DONE), 64'h1);
    run_to_idle();
    check("cnt0_q", 64'(Q), 64'h12345678);
    check("cnt0_busy_cycles", 64'(busy_cnt), 64'd0);

    // Long count filling from zero with ones.
    load(32'h00000000);
    cycle(1'b1, 1'b0, 1'b1, 3'b101, 31, 1'b1, '0);
    run_to_idle();
    check("cnt31_q", 64'(Q), 64'h7FFFFFFF);

    // Reset in the middle of a run: no DONE afterwards, next START works.
    load(32'hDEADBEEF);
    cycle(1'b1, 1'b1, 1'b0, 3'b101, 10, 1'b1, '0);
    junk_cycle(1'b1);
    junk_cycle(1'b1);
    check("pre_reset_busy", 64'(BUSY), 64'h1);
    busy_cnt = 0; done_cnt = 0;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 3'b000, 0, 1'b0, '0);
    check("reset_no_done", 64'(done_cnt), 64'd0);
    load(32'h0000000F);
    cycle(1'b1, 1'b0, 1'b1, 3'b101, 2, 1'b1, '0);
    run_to_idle();
    check("after_reset_q", 64'(Q), 64'h0000003F);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int c;
      c = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5);
      cycle(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 3'($urandom), c,
            1'($urandom), $urandom);
    end

    @(posedge CLK);
    #2;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
